// File: rtl/sr_latch_write_arbiter.sv
// Round-robin write arbiter for a bank of gated SR latches: sequences setup,
// enable pulse, hold and readback so that s and r are never high together.
module sr_latch_write_arbiter #(
    parameter int W         = 8,
    parameter int PULSE_CYC = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] wdata0,
    input  logic [W-1:0] wdata1,
    input  logic [W-1:0] wmask0,
    input  logic [W-1:0] wmask1,
    output logic         ack0,
    output logic         ack1,
    output logic [W-1:0] latch_s,
    output logic [W-1:0] latch_r,
    output logic         latch_en,
    input  logic [W-1:0] latch_q,
    output logic         busy,
    output logic         grant,
    output logic         err
);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;

    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYC - 1);

    state_t       state;
    logic         ptr;
    logic [3:0]   pulse_cnt;
    logic [W-1:0] data_c;
    logic [W-1:0] mask_c;
    logic         any_req;
    logic         pick;
    logic [W-1:0] sel_data;
    logic [W-1:0] sel_mask;

    // On contention the pointer chooses; otherwise whichever request is present wins.
    always_comb begin
        any_req  = req0 | req1;
        pick     = (req0 && req1) ? ptr : req1;
        sel_data = pick ? wdata1 : wdata0;
        sel_mask = pick ? wmask1 : wmask0;
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && any_req) begin
            data_c <= sel_data;
            mask_c <= sel_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            pulse_cnt <= '0;
            latch_s   <= '0;
            latch_r   <= '0;
            latch_en  <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            busy      <= 1'b0;
            grant     <= 1'b0;
            err       <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state   <= SETUP;
                        grant   <= pick;
                        ptr     <= ~pick;
                        busy    <= 1'b1;
                        // data_c is not loaded yet, so drive s/r from the selected inputs
                        latch_s <= sel_data & sel_mask;
                        latch_r <= ~sel_data & sel_mask;
                    end
                end
                SETUP: begin
                    state     <= PULSE;
                    latch_en  <= 1'b1;
                    pulse_cnt <= PULSE_LOAD;
                end
                PULSE: begin
                    if (pulse_cnt == 4'd0) begin
                        state    <= HOLD;
                        latch_en <= 1'b0;
                        latch_s  <= '0;
                        latch_r  <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    // latch_q here has had a full cycle to settle after enable fell
                    state <= DONE;
                    ack0  <= ~grant;
                    ack1  <= grant;
                    if (|((latch_q ^ data_c) & mask_c)) begin
                        err <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_write_arbiter.sv
// Bench for sr_latch_write_arbiter: behavioural latch bank, scoreboard of
// expected write completions, plus short-pulse and long-pulse instances.
module tb_sr_latch_write_arbiter;

    localparam int PC = 2;

    typedef struct {
        logic       id;
        logic [7:0] q;
        logic       err;
        int         ack_cyc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       req0, req1;
    logic [7:0] wdata0, wdata1, wmask0, wmask1;
    logic       ack0, ack1;
    logic [7:0] latch_s, latch_r, latch_q;
    logic       latch_en, busy, grant, err;

    logic [7:0] bank = 8'h00;
    logic [7:0] fault_mask = 8'h00;

    logic       x_req   [2];
    logic       x_ack0  [2];
    logic       x_ack1  [2];
    logic [7:0] x_s     [2];
    logic [7:0] x_r     [2];
    logic       x_en    [2];
    logic       x_busy  [2];
    logic       x_grant [2];
    logic       x_err   [2];
    logic [7:0] x_bank  [2];
    logic [7:0] x_wdata, x_wmask;
    logic       x_zero;
    logic [7:0] x_zero_w;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [7:0] model_bank = 8'h00;
    logic       model_err = 1'b0;
    bit   mon_on = 0;
    bit   contention = 0;
    int   prev_ack = -1;
    logic ack_last = 1'b0;

    sr_latch_write_arbiter #(.W(8), .PULSE_CYC(PC)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .wdata0(wdata0), .wdata1(wdata1), .wmask0(wmask0), .wmask1(wmask1),
        .ack0(ack0), .ack1(ack1),
        .latch_s(latch_s), .latch_r(latch_r), .latch_en(latch_en), .latch_q(latch_q),
        .busy(busy), .grant(grant), .err(err)
    );

    sr_latch_write_arbiter #(.W(8), .PULSE_CYC(1)) u_p1 (
        .clk(clk), .reset(reset),
        .req0(x_req[0]), .req1(x_zero),
        .wdata0(x_wdata), .wdata1(x_zero_w), .wmask0(x_wmask), .wmask1(x_zero_w),
        .ack0(x_ack0[0]), .ack1(x_ack1[0]),
        .latch_s(x_s[0]), .latch_r(x_r[0]), .latch_en(x_en[0]), .latch_q(x_bank[0]),
        .busy(x_busy[0]), .grant(x_grant[0]), .err(x_err[0])
    );

    sr_latch_write_arbiter #(.W(8), .PULSE_CYC(15)) u_p15 (
        .clk(clk), .reset(reset),
        .req0(x_req[1]), .req1(x_zero),
        .wdata0(x_wdata), .wdata1(x_zero_w), .wmask0(x_wmask), .wmask1(x_zero_w),
        .ack0(x_ack0[1]), .ack1(x_ack1[1]),
        .latch_s(x_s[1]), .latch_r(x_r[1]), .latch_en(x_en[1]), .latch_q(x_bank[1]),
        .busy(x_busy[1]), .grant(x_grant[1]), .err(x_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Gated SR latch bank: transparent while enable is high, fault forces q bits low.
    always @(negedge clk) begin
        if (latch_en) bank <= (bank & ~latch_r) | latch_s;
        for (int i = 0; i < 2; i++) begin
            if (x_en[i]) x_bank[i] <= (x_bank[i] & ~x_r[i]) | x_s[i];
        end
    end
    assign latch_q = bank & ~fault_mask;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (mon_on) begin
            check("s_and_r", {24'h0, latch_s & latch_r}, 32'h0);
            check("ack_both", {31'h0, ack0 & ack1}, 32'h0);
            check("ack_width", {31'h0, ack_last & (ack0 | ack1)}, 32'h0);
            if (ack0 || ack1) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", {30'h0, ack1, ack0}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("ack_id", {30'h0, ack1, ack0}, e.id ? 32'd2 : 32'd1);
                    check("grant", {31'h0, grant}, {31'h0, e.id});
                    check("readback", {24'h0, latch_q}, {24'h0, e.q});
                    check("err", {31'h0, err}, {31'h0, e.err});
                    if (e.ack_cyc >= 0) check("ack_cycle", cyc, e.ack_cyc);
                    if (contention && prev_ack >= 0) check("ack_spacing", cyc - prev_ack, 6);
                    prev_ack = cyc;
                end
            end
            ack_last = ack0 | ack1;
        end
    end

    function automatic exp_t predict(input logic id, input logic [7:0] d, input logic [7:0] m,
                                     input int ack_cyc);
        exp_t e;
        logic [7:0] q;
        model_bank = (model_bank & ~m) | (d & m);
        q = model_bank & ~fault_mask;
        model_err = model_err | (((q ^ d) & m) != 8'h00);
        e.id = id;
        e.q = q;
        e.err = model_err;
        e.ack_cyc = ack_cyc;
        return e;
    endfunction

    task automatic run_write(input logic id, input logic [7:0] d, input logic [7:0] m);
        int k, en_n, guard;
        bit got;
        logic [7:0] s_exp, r_exp;
        guard = 0;
        @(posedge clk); #1;
        while (busy && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        k = cyc;
        sb.push_back(predict(id, d, m, k + 3 + PC));
        if (id) begin req1 = 1'b1; wdata1 = d; wmask1 = m; end
        else    begin req0 = 1'b1; wdata0 = d; wmask0 = m; end
        @(posedge clk); #1;
        s_exp = d & m;
        r_exp = ~d & m;
        check("setup_s", {24'h0, latch_s}, {24'h0, s_exp});
        check("setup_r", {24'h0, latch_r}, {24'h0, r_exp});
        check("setup_en", {31'h0, latch_en}, 32'h0);
        check("setup_busy", {31'h0, busy}, 32'h1);
        check("setup_grant", {31'h0, grant}, {31'h0, id});
        // Late input changes must not leak into the write in progress.
        if (id) begin wdata1 = ~d; wmask1 = 8'hFF; end
        else    begin wdata0 = ~d; wmask0 = 8'hFF; end
        en_n = 0;
        got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(posedge clk); #1;
            if (latch_en) en_n++;
            if (cyc == k + 2 + PC) begin
                check("hold_s_r_en", {15'h0, latch_en, latch_s, latch_r}, 32'h0);
            end
            if (ack0 || ack1) begin
                got = 1;
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        check("ack_seen", {31'h0, got}, 32'h1);
        check("en_cycles", en_n, PC);
        @(posedge clk); #1;
    endtask

    task automatic run_short(input int i, input int pc, input logic [7:0] d, input logic [7:0] m,
                             input logic [7:0] bank_exp);
        int k, en_n;
        bit got;
        @(posedge clk); #1;
        k = cyc;
        x_wdata = d;
        x_wmask = m;
        x_req[i] = 1'b1;
        en_n = 0;
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1;
            check("p_s_and_r", {24'h0, x_s[i] & x_r[i]}, 32'h0);
            if (x_en[i]) en_n++;
            if (x_ack0[i]) begin
                got = 1;
                x_req[i] = 1'b0;
                check("p_ack_cycle", cyc, k + 3 + pc);
                check("p_ack1", {31'h0, x_ack1[i]}, 32'h0);
                check("p_err", {31'h0, x_err[i]}, 32'h0);
                check("p_grant", {31'h0, x_grant[i]}, 32'h0);
            end
        end
        x_req[i] = 1'b0;
        check("p_ack_seen", {31'h0, got}, 32'h1);
        check("p_en_cycles", en_n, pc);
        check("p_bank", {24'h0, x_bank[i]}, {24'h0, bank_exp});
        @(posedge clk); #1;
        check("p_idle", {31'h0, x_busy[i]}, 32'h0);
    endtask

    initial begin
        int k, n;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        wdata0 = 8'h00; wdata1 = 8'h00; wmask0 = 8'h00; wmask1 = 8'h00;
        x_req[0] = 1'b0; x_req[1] = 1'b0;
        x_wdata = 8'h00; x_wmask = 8'h00;
        x_zero = 1'b0; x_zero_w = 8'h00;
        x_bank[0] = 8'h00; x_bank[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_grant", {31'h0, grant}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_en", {31'h0, latch_en}, 32'h0);
        check("rst_s_r", {16'h0, latch_s, latch_r}, 32'h0);
        check("rst_acks", {30'h0, ack1, ack0}, 32'h0);
        reset = 1'b0;
        mon_on = 1;

        run_write(1'b0, 8'hA5, 8'hFF);
        run_write(1'b1, 8'h0F, 8'hF0);

        fault_mask = 8'h08;
        run_write(1'b0, 8'hFF, 8'hFF);
        fault_mask = 8'h00;
        run_write(1'b1, 8'h00, 8'hFF);
        run_write(1'b0, 8'h5A, 8'hFF);

        // Reset during the second enable cycle.
        k = cyc;
        req0 = 1'b1; wdata0 = 8'h33; wmask0 = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("mid_pulse_en", {31'h0, latch_en}, 32'h1);
        check("mid_pulse_cycle", cyc, k + 3);
        reset = 1'b1;
        req0 = 1'b0;
        @(posedge clk); #1;
        check("abort_en", {31'h0, latch_en}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_ack", {30'h0, ack1, ack0}, 32'h0);
        check("abort_err", {31'h0, err}, 32'h0);
        reset = 1'b0;
        model_err = 1'b0;
        model_bank = 8'h33;
        run_write(1'b0, 8'h96, 8'hFF);

        // Both requesters held high from reset.
        @(posedge clk); #1;
        reset = 1'b1;
        req0 = 1'b1; wdata0 = 8'h3C; wmask0 = 8'hFF;
        req1 = 1'b1; wdata1 = 8'hC3; wmask1 = 8'h0F;
        model_err = 1'b0;
        for (int j = 0; j < 4; j++) sb.push_back(predict(j[0], j[0] ? 8'hC3 : 8'h3C, j[0] ? 8'h0F : 8'hFF, -1));
        contention = 1;
        prev_ack = -1;
        @(posedge clk); #1;
        reset = 1'b0;
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(posedge clk); #1;
            if (ack0 || ack1) n++;
            if (n == 4) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("contention_acks", n, 4);
        @(posedge clk); #1;
        contention = 0;

        run_short(0, 1, 8'hAA, 8'hFF, 8'hAA);
        run_short(0, 1, 8'h55, 8'h00, 8'hAA);
        run_short(1, 15, 8'hAA, 8'hFF, 8'hAA);
        run_short(1, 15, 8'h55, 8'h00, 8'hAA);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        check("final_busy", {31'h0, busy}, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sr_latch_write_arbiter.md
# sr_latch_write_arbiter

Synchronous controller that shares one bank of W gated SR latches between two write requesters. It arbitrates round-robin, then sequences each granted write as setup, enable pulse, hold and readback check. It drives the bank's per-bit s/r lines and common enable so that s=r=1 never reaches a latch. It sits between the clocked request logic and the latch-bank storage built from the gated SR latch cell.

## Interface
Parameters:
- W, 8, latch bank width in bits
- PULSE_CYC, 2, cycles the latch enable is held high per write (legal 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req0 / req1  input  1  write request from requester 0 / 1; held high until its ack
- wdata0 / wdata1  input  W  data to store
- wmask0 / wmask1  input  W  per-bit write mask; a 0 bit leaves that latch unchanged
- ack0 / ack1  output  1  one-cycle write-complete pulse to requester 0 / 1
- latch_s  output  W  per-bit set line to the bank
- latch_r  output  W  per-bit reset line to the bank
- latch_en  output  1  common enable to the bank
- latch_q  input  W  bank q outputs, used for readback
- busy  output  1  high in every state except IDLE
- grant  output  1  index of the requester being served; valid while busy
- err  output  1  sticky readback-mismatch flag; cleared only by reset

## Operation
- Clock and reset: one clock. Reset is synchronous and active-high.
- States: IDLE, SETUP, PULSE, HOLD, DONE.
- IDLE
  - No request: stay in IDLE.
  - A request present: grant it, capture that requester's wdata and wmask into internal registers (data_c, mask_c), and go to SETUP.
- Arbitration
  - If only one request is high, grant it.
  - If both are high, grant the requester not served last (the priority pointer).
  - The pointer updates at each grant.
  - After reset the pointer favours requester 0.
- SETUP (1 cycle)
  - latch_s = data_c & mask_c
  - latch_r = ~data_c & mask_c
  - latch_en = 0
- PULSE (PULSE_CYC cycles)
  - latch_s and latch_r as in SETUP, latch_en = 1.
  - A down-counter loaded with PULSE_CYC-1 on entry sets the length; exit to HOLD when it reaches 0.
- HOLD (1 cycle)
  - latch_en = 0, latch_s = 0, latch_r = 0.
- DONE (1 cycle)
  - Assert ack for the granted requester.
  - If (latch_q ^ data_c) & mask_c is nonzero, set err.
  - Return to IDLE.
- Invariant: latch_s & latch_r == 0 on every cycle.
  - Outside SETUP and PULSE, latch_s and latch_r are all zero.
- Mask all zero: the full sequence still runs and ack is still issued. No latch changes and no error is possible.
- Inputs during a write: wdata and wmask changes after the grant are ignored.
- Request removal:
  - A req dropped mid-sequence does not abort it; the ack is still issued.
  - A req still high in the IDLE cycle after its ack is treated as a new request.

## Timing
- All outputs are registered.
- Reset values: latch_s=0, latch_r=0, latch_en=0, ack0=0, ack1=0, busy=0, grant=0, err=0, state IDLE, pointer favouring 0.
- Reset mid-operation: at the next edge all outputs take their reset values and the state is IDLE. latch_en drops without a HOLD cycle; bank contents are undefined for that write.
- Write cycle, with req sampled high in IDLE at edge k:
  - SETUP is visible after edge k+1.
  - PULSE is visible after edges k+2 .. k+1+PULSE_CYC.
  - HOLD is visible after edge k+2+PULSE_CYC.
  - ack is visible after edge k+3+PULSE_CYC, for one cycle.
  - IDLE is reached after edge k+4+PULSE_CYC.
- Throughput: one write per PULSE_CYC+4 cycles. With PULSE_CYC=2 that is 6 cycles per write and ack at k+5.
- Readback: latch_q is sampled in DONE, one full cycle after latch_en fell.
- busy: high from edge k+1 through the DONE cycle.
- grant: stable from edge k+1 through the DONE cycle.

## Test plan
- Reset then single write:
  - Stimulus: W=8, PULSE_CYC=2; req0 with wdata0=8'hA5, wmask0=8'hFF.
  - SETUP: latch_s=8'hA5, latch_r=8'h5A, en=0.
  - PULSE: en=1 for exactly 2 cycles.
  - HOLD: all zero.
  - Result: ack0 pulses at k+5, bank reads 8'hA5, err=0.
- Masked write:
  - Stimulus: bank holds 8'hA5; req1 with wdata1=8'h0F, wmask1=8'hF0.
  - Required: latch_s=8'h00, latch_r=8'hF0, bank becomes 8'h05, ack1 pulses, grant=1.
- Contention:
  - Stimulus: req0 and req1 both held high from reset.
  - Required: grants alternate 0,1,0,1.
  - Required: each ack is one cycle wide and acks are 6 cycles apart.
  - Required: latch_s & latch_r = 0 on every cycle.
- Readback fault:
  - Stimulus: the bench model forces latch_q bit 3 to 0; write 8'hFF with mask 8'hFF.
  - Required: err rises in DONE and stays high through later good writes until reset.
- Reset mid-PULSE:
  - Stimulus: assert reset during the second PULSE cycle.
  - Required: at the next edge latch_en=0, busy=0, no ack issued.
  - Required: a subsequent req0 is granted normally.
- PULSE_CYC=1 and PULSE_CYC=15:
  - Required: latch_en is high for exactly 1 / 15 cycles.
  - Required: ack arrives at k+4 / k+18.
  - Required: an all-zero mask still produces an ack and no bank change.
